md_unit: RTL and testbench

//  Parametrised multiply/divide unit owning the HI/LO register pair for the pipelined

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_result_calc.sv | 79 +++++++
 rtl/md_unit.sv | 145 ++++++++++++++
 tb/tb_md_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings and types for the multiply/divide unit
//
// Purpose: operation codes understood by md_unit, the FSM state type and the
// HI/LO read-select constants used by the mdOut mux.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic MD_SEL_HI = 1'b0;
    localparam logic MD_SEL_LO = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

endpackage

// File: rtl/md_result_calc.sv
// rtl/md_result_calc.sv - combinational HI/LO result for mult/multu/div/divu
//
// Purpose: computes the HI/LO pair written when a multi-cycle operation retires.
// Ports:
//   opA, opB  captured operands (dividend/multiplicand, divisor/multiplier)
//   op        captured operation code (md_pkg encoding)
//   hiNext    value for HI (product high half or remainder)
//   loNext    value for LO (product low half or quotient)
module md_result_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] hiNext,
    output logic [WIDTH-1:0] loNext
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                     divZero;
    logic                     divOvf;
    logic [WIDTH-1:0]         safeB;
    logic signed [2*WIDTH-1:0] sProd;
    logic [2*WIDTH-1:0]       uProd;
    logic signed [WIDTH-1:0]  sQuot;
    logic signed [WIDTH-1:0]  sRem;
    logic [WIDTH-1:0]         uQuot;
    logic [WIDTH-1:0]         uRem;

    assign divZero = (opB == '0);
    assign divOvf  = (opA == MOST_NEG) && (opB == '1);

    // The special cases are resolved below; feeding the dividers a harmless
    // divisor keeps them away from the undefined zero / overflow corners.
    assign safeB = (divZero || divOvf) ? {{(WIDTH-1){1'b0}}, 1'b1} : opB;

    assign sProd = $signed({{WIDTH{opA[WIDTH-1]}}, opA}) * $signed({{WIDTH{opB[WIDTH-1]}}, opB});
    assign uProd = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};

    assign sQuot = $signed(opA) / $signed(safeB);
    assign sRem  = $signed(opA) % $signed(safeB);
    assign uQuot = opA / safeB;
    assign uRem  = opA % safeB;

    always_comb begin
        hiNext = '0;
        loNext = '0;
        case (op)
            MD_MULT:  {hiNext, loNext} = sProd;
            MD_MULTU: {hiNext, loNext} = uProd;
            MD_DIV: begin
                if (divZero) begin
                    hiNext = opA;
                    loNext = '1;
                end else if (divOvf) begin
                    hiNext = '0;
                    loNext = opA;
                end else begin
                    hiNext = sRem;
                    loNext = sQuot;
                end
            end
            MD_DIVU: begin
                if (divZero) begin
                    hiNext = opA;
                    loNext = '1;
                end else begin
                    hiNext = uRem;
                    loNext = uQuot;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multiply/divide unit owning the HI/LO register pair
//
// Purpose: E-stage mult/multu/div/divu with fixed latency, single-cycle mthi/mtlo,
// busy for the hazard unit and a HI/LO read mux.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    issue mdOp this cycle
//   mdOp     operation code (md_pkg encoding)
//   flush    suppresses issue this cycle (does not cancel an op in flight)
//   rsData   operand A / mthi-mtlo data
//   rtData   operand B
//   hiloSel  read select: 0 = HI, 1 = LO
//   busy     multi-cycle operation in flight
//   mdOut    hiloSel ? LO : HI
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic             flush,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic             hiloSel,
    output logic             busy,
    output logic [WIDTH-1:0] mdOut
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    mdState_t         state;
    mdState_t         nextState;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [2:0]       opReg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hiNext;
    logic [WIDTH-1:0] loNext;

    logic accept;
    logic loadMult;
    logic loadDiv;
    logic writeHi;
    logic writeLo;
    logic finish;

    md_result_calc #(
        .WIDTH (WIDTH)
    ) uCalc (
        .opA    (opA),
        .opB    (opB),
        .op     (opReg),
        .hiNext (hiNext),
        .loNext (loNext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        loadMult  = 1'b0;
        loadDiv   = 1'b0;
        writeHi   = 1'b0;
        writeLo   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                accept = start && !flush;
                if (accept) begin
                    case (mdOp)
                        MD_MULT, MD_MULTU: begin
                            loadMult  = 1'b1;
                            nextState = RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            loadDiv   = 1'b1;
                            nextState = RUN;
                        end
                        MD_MTHI: writeHi = 1'b1;
                        MD_MTLO: writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Flush is deliberately ignored here: the op in flight completes.
                if (count == '0) begin
                    finish    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            opA   <= '0;
            opB   <= '0;
            opReg <= MD_MULT;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (loadMult || loadDiv) begin
                opA   <= rsData;
                opB   <= rtData;
                opReg <= mdOp;
                count <= loadMult ? MULT_CNT : DIV_CNT;
            end else if (state == RUN && count != '0) begin
                count <= count - CNT_W'(1);
            end

            if (finish) begin
                hi <= hiNext;
                lo <= loNext;
            end else begin
                if (writeHi) hi <= rsData;
                if (writeLo) lo <= rsData;
            end
        end
    end

    assign busy  = (state == RUN);
    assign mdOut = (hiloSel == MD_SEL_LO) ? lo : hi;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;
    import md_pkg::*;

    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        mdOp;
    logic              flush;
    logic [WIDTH-1:0]  rsData;
    logic [WIDTH-1:0]  rtData;
    logic              hiloSel;
    logic              busy;
    logic [WIDTH-1:0]  mdOut;

    int nPass  = 0;
    int nTotal = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;

    md_unit #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdOp    (mdOp),
        .flush   (flush),
        .rsData  (rsData),
        .rtData  (rtData),
        .hiloSel (hiloSel),
        .busy    (busy),
        .mdOut   (mdOut)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: HI/LO from the architectural definition using 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, ma, mb, q, r;
        logic [63:0] p;
        case (op)
            MD_MULT: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p = la * lb;
                refHi = p[63:32];
                refLo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                refHi = p[63:32];
                refLo = p[31:0];
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    refLo = 32'hFFFFFFFF;
                    refHi = a;
                end else if (op == MD_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    refLo = a;
                    refHi = 32'd0;
                end else begin
                    if (op == MD_DIV) begin
                        la = longint'($signed(a));
                        lb = longint'($signed(b));
                    end else begin
                        la = longint'({32'b0, a});
                        lb = longint'({32'b0, b});
                    end
                    ma = (la < 0) ? -la : la;
                    mb = (lb < 0) ? -lb : lb;
                    q = ma / mb;
                    r = ma % mb;
                    if ((la < 0) != (lb < 0)) q = -q;
                    if (la < 0) r = -r;
                    refLo = q[31:0];
                    refHi = r[31:0];
                end
            end
            MD_MTHI: refHi = a;
            MD_MTLO: refLo = a;
            default: ;
        endcase
    endtask

    // Drives one issue cycle (inputs set ~1 time unit after an edge) and updates the model.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, output logic acc);
        start  = 1'b1;
        mdOp   = op;
        rsData = a;
        rtData = b;
        flush  = fl;
        acc    = !fl && (busy === 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        if (acc) model(op, a, b);
    endtask

    // Counts post-edge samples with busy high; an expired bound is a failed comparison.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 200) begin
            nTotal++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        hiloSel = MD_SEL_HI;
        #1;
        hi = mdOut;
        hiloSel = MD_SEL_LO;
        #1;
        lo = mdOut;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        logic acc;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        read_hilo(hi, lo);
        nTotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else nPass++;
        nTotal++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else nPass++;
        nTotal++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else nPass++;

        // Abandon a multiply mid-flight with HI/LO holding nonzero data.
        @(posedge clk); #1;
        issue(MD_MTHI, 32'hAAAA0000, 32'd0, 1'b0, acc);
        issue(MD_MTLO, 32'h00005555, 32'd0, 1'b0, acc);
        issue(MD_MULT, 32'd9, 32'd9, 1'b0, acc);
        @(posedge clk); #1;
        nTotal++; if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", busy); else nPass++;
        #2 reset = 1'b0;
        #1;
        nTotal++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b want 0", busy); else nPass++;
        @(posedge clk); #1;
        reset = 1'b1;
        refHi = '0;
        refLo = '0;
        repeat (MULT_LAT + 2) @(posedge clk);
        #1;
        read_hilo(hi, lo);
        nTotal++; if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy); else nPass++;
        nTotal++; if (hi !== 32'd0) $display("FAIL reset_mid_hi: got %h want 0", hi); else nPass++;
        nTotal++; if (lo !== 32'd0) $display("FAIL reset_mid_lo: got %h want 0", lo); else nPass++;
    endtask

    task automatic test_mult();
        logic [31:0] hi, lo;
        logic acc;
        int n;
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, acc);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (n !== MULT_LAT) $display("FAIL mult_latency: got %0d want %0d", n, MULT_LAT); else nPass++;
        nTotal++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else nPass++;
        nTotal++; if (lo !== 32'hFFFFFFEB) $display("FAIL mult_lo: got %h want ffffffeb", lo); else nPass++;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, acc);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (hi !== 32'd1) $display("FAIL multu_hi: got %h want 1", hi); else nPass++;
        nTotal++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo: got %h want fffffffe", lo); else nPass++;
    endtask

    task automatic test_div();
        logic [31:0] hi, lo;
        logic acc;
        int n;
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, acc);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (n !== DIV_LAT) $display("FAIL div_latency: got %0d want %0d", n, DIV_LAT); else nPass++;
        nTotal++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", lo); else nPass++;
        nTotal++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", hi); else nPass++;
        issue(MD_DIVU, 32'd7, 32'd0, 1'b0, acc);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (lo !== 32'hFFFFFFFF) $display("FAIL divu_zero_lo: got %h want ffffffff", lo); else nPass++;
        nTotal++; if (hi !== 32'd7) $display("FAIL divu_zero_hi: got %h want 7", hi); else nPass++;
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, acc);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else nPass++;
        nTotal++; if (hi !== 32'd0) $display("FAIL div_ovf_hi: got %h want 0", hi); else nPass++;
    endtask

    task automatic test_mt();
        start = 1'b1; flush = 1'b0;
        mdOp = MD_MTHI; rsData = 32'h1234; rtData = 32'hDEAD;
        @(posedge clk); #1;
        nTotal++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else nPass++;
        hiloSel = MD_SEL_HI; #1;
        nTotal++; if (mdOut !== 32'h1234) $display("FAIL mthi_value: got %h want 1234", mdOut); else nPass++;
        mdOp = MD_MTLO; rsData = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        nTotal++; if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", busy); else nPass++;
        hiloSel = MD_SEL_LO; #1;
        nTotal++; if (mdOut !== 32'h5678) $display("FAIL mtlo_value: got %h want 5678", mdOut); else nPass++;
        hiloSel = MD_SEL_HI; #1;
        nTotal++; if (mdOut !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h want 1234", mdOut); else nPass++;
        refHi = 32'h1234;
        refLo = 32'h5678;
    endtask

    task automatic test_flush_issue();
        logic [31:0] hi, lo;
        logic acc;
        issue(MD_MULT, 32'd3, 32'd4, 1'b1, acc);
        nTotal++; if (busy !== 1'b0) $display("FAIL flush_issue_busy: got %b want 0", busy); else nPass++;
        repeat (MULT_LAT + 1) @(posedge clk);
        #1;
        read_hilo(hi, lo);
        nTotal++; if (hi !== refHi) $display("FAIL flush_issue_hi: got %h want %h", hi, refHi); else nPass++;
        nTotal++; if (lo !== refLo) $display("FAIL flush_issue_lo: got %h want %h", lo, refLo); else nPass++;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] hi, lo;
        logic acc, acc2;
        int n;
        issue(MD_MULT, 32'd5, 32'd6, 1'b0, acc);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, acc2);
        wait_idle(n);
        read_hilo(hi, lo);
        nTotal++; if (n + 1 !== MULT_LAT) $display("FAIL busy_ignore_latency: got %0d want %0d", n + 1, MULT_LAT); else nPass++;
        nTotal++; if (hi !== 32'd0) $display("FAIL busy_ignore_hi: got %h want 0", hi); else nPass++;
        nTotal++; if (lo !== 32'd30) $display("FAIL busy_ignore_lo: got %h want 1e", lo); else nPass++;
    endtask

    task automatic test_flush_mid_run();
        logic [31:0] hi, lo;
        logic acc;
        int n;
        issue(MD_DIV, 32'd1000, 32'hFFFFFFF9, 1'b0, acc);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            flush  = $urandom_range(0, 1);
            rsData = $urandom;
            rtData = $urandom;
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        read_hilo(hi, lo);
        nTotal++; if (n !== DIV_LAT) $display("FAIL flush_mid_latency: got %0d want %0d", n, DIV_LAT); else nPass++;
        nTotal++; if (lo !== refLo) $display("FAIL flush_mid_lo: got %h want %h", lo, refLo); else nPass++;
        nTotal++; if (hi !== refHi) $display("FAIL flush_mid_hi: got %h want %h", hi, refHi); else nPass++;
    endtask

    task automatic test_random();
        logic [31:0] specials [5];
        logic [31:0] hi, lo, a, b;
        logic [2:0] op;
        logic fl, acc;
        int n, expN;
        specials[0] = 32'd0;
        specials[1] = 32'd1;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            fl = ($urandom_range(0, 4) == 0);
            issue(op, a, b, fl, acc);
            wait_idle(n);
            if (acc && (op == MD_MULT || op == MD_MULTU)) expN = MULT_LAT;
            else if (acc && (op == MD_DIV || op == MD_DIVU)) expN = DIV_LAT;
            else expN = 0;
            read_hilo(hi, lo);
            nTotal++; if (n !== expN) $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, op, n, expN); else nPass++;
            nTotal++; if (hi !== refHi) $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, hi, refHi); else nPass++;
            nTotal++; if (lo !== refLo) $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, lo, refLo); else nPass++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mdOp    = MD_MULT;
        flush   = 1'b0;
        rsData  = '0;
        rtData  = '0;
        hiloSel = MD_SEL_HI;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_flush_issue();
        test_busy_ignore();
        test_flush_mid_run();
        test_random();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
